hpi_bus_master: RTL and testbench

- Parametrised, self-timed host-port bus master for the EZ-OTG HPI and similar async 16-bit peripherals.
- Sits between an on-chip requester (NIOS PIO glue or hardware FSM) and the chip pins.
- Replaces software-driven strobes with one request/response handshake per transaction.
- Generates programmable setup/strobe/hold timing, tristate control and a timed chip-reset pulse.

---
 rtl/hpi_bus_master_if.sv | 36 +++
 rtl/hpi_bus_master.sv | 239 +++++++++++++++++++++++
 tb/tb_hpi_bus_master.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpi_bus_master_if.sv
// hpi_bus_master_if: request/response handshake plus chip-pin controls for the
// HPI bus master. The bidirectional data bus is a plain inout on the master so
// that tristate resolution stays at module-port level.
interface hpi_bus_master_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  // Requester side
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              chip_rst_req;
  logic              busy;
  // Chip pins (active-low controls)
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rd_n;
  logic              bus_wr_n;
  logic              bus_cs_n;
  logic              bus_rst_n;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, chip_rst_req,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output bus_addr, bus_rd_n, bus_wr_n, bus_cs_n, bus_rst_n
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, chip_rst_req,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  bus_addr, bus_rd_n, bus_wr_n, bus_cs_n, bus_rst_n
  );
endinterface

// File: rtl/hpi_bus_master.sv
// hpi_bus_master: self-timed bus master for the EZ-OTG HPI and similar async
// 16-bit peripherals. One request/response handshake per transaction produces
// registered CS/address/strobe/data timing (setup, strobe, hold) and a timed
// chip-reset pulse. Every pin and the data output-enable come from flops.
//
// Optional build macro: HPI_TURNAROUND_EN -- inserts a 2-cycle TURN state after
// HOLD (CS_N high, data released) so the minimum CS_N-high gap becomes 3 cycles.
module hpi_bus_master #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 1,   // 1..15
  parameter int STROBE_CYC = 2,   // 1..15
  parameter int HOLD_CYC   = 1,   // 1..15
  parameter int RST_CYC    = 8    // 1..255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  hpi_bus_master_if.master  bus,
  inout  wire [DATA_W-1:0]  io_bus_data
);

  // Counter reload values: the counter runs from N-1 down to 0, so each state
  // lasts exactly N cycles.
  localparam logic [7:0] L_SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] L_STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] L_HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] L_RST_LD    = 8'(RST_CYC - 1);
  localparam logic [7:0] L_TURN_LD   = 8'd1;

  typedef enum logic [2:0] {
    ST_CHIPRST = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_TURN    = 3'd5
  } state_t;

  // State and timing
  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_rst_pend;
  logic              r_write;
  // Pin registers
  logic              r_cs_n;
  logic              r_rd_n;
  logic              r_wr_n;
  logic              r_chip_rst_n;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;
  logic              r_data_oe;
  // Response registers
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  // Next-state values
  state_t            w_state_next;
  logic [7:0]        w_cnt_next;
  logic              w_rst_pend_next;
  logic              w_write_next;
  logic              w_cs_n_next;
  logic              w_rd_n_next;
  logic              w_wr_n_next;
  logic              w_chip_rst_n_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic [DATA_W-1:0] w_dout_next;
  logic              w_data_oe_next;
  logic              w_rsp_valid_next;
  logic [DATA_W-1:0] w_rsp_rdata_next;

  logic              w_rst_hit;
  logic              w_req_ready;
  logic              w_cnt_zero;
  logic [7:0]        w_cnt_dec;

  // A reset request (new or left pending from a transaction) blocks acceptance.
  assign w_rst_hit   = bus.chip_rst_req | r_rst_pend;
  assign w_req_ready = (r_state == ST_IDLE) && !w_rst_hit;
  assign w_cnt_zero  = (r_cnt == 8'd0);
  assign w_cnt_dec   = r_cnt - 8'd1;

  // Next-state and next-pin decode; every value defaults to "hold".
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_rst_pend_next   = r_rst_pend;
    w_write_next      = r_write;
    w_cs_n_next       = r_cs_n;
    w_rd_n_next       = r_rd_n;
    w_wr_n_next       = r_wr_n;
    w_chip_rst_n_next = r_chip_rst_n;
    w_addr_next       = r_addr;
    w_dout_next       = r_dout;
    w_data_oe_next    = r_data_oe;
    w_rsp_valid_next  = 1'b0;
    w_rsp_rdata_next  = r_rsp_rdata;

    // Reset requests arriving mid-transaction wait until the bus is back in
    // IDLE; requests during CHIPRST are dropped (counter not restarted).
    if (bus.chip_rst_req && (r_state != ST_IDLE) && (r_state != ST_CHIPRST)) begin
      w_rst_pend_next = 1'b1;
    end

    case (r_state)
      ST_CHIPRST: begin
        if (w_cnt_zero) begin
          w_state_next      = ST_IDLE;
          w_chip_rst_n_next = 1'b1;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end

      ST_IDLE: begin
        if (w_rst_hit) begin
          // Reset wins over a simultaneous request.
          w_state_next      = ST_CHIPRST;
          w_cnt_next        = L_RST_LD;
          w_chip_rst_n_next = 1'b0;
          w_rst_pend_next   = 1'b0;
        end else if (bus.req_valid) begin
          w_state_next   = ST_SETUP;
          w_cnt_next     = L_SETUP_LD;
          w_write_next   = bus.req_write;
          w_addr_next    = bus.req_addr;
          w_dout_next    = bus.req_wdata;
          w_data_oe_next = bus.req_write;  // reads never drive the bus
          w_cs_n_next    = 1'b0;
        end
      end

      ST_SETUP: begin
        if (w_cnt_zero) begin
          w_state_next = ST_STROBE;
          w_cnt_next   = L_STROBE_LD;
          w_rd_n_next  = r_write;
          w_wr_n_next  = !r_write;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end

      ST_STROBE: begin
        if (w_cnt_zero) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = L_HOLD_LD;
          w_rd_n_next  = 1'b1;
          w_wr_n_next  = 1'b1;
          // Capture on the edge that ends the last strobe cycle.
          if (!r_write) begin
            w_rsp_rdata_next = io_bus_data;
          end
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end

      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_cs_n_next      = 1'b1;
          w_data_oe_next   = 1'b0;
          w_rsp_valid_next = 1'b1;
`ifdef HPI_TURNAROUND_EN
          w_state_next     = ST_TURN;
          w_cnt_next       = L_TURN_LD;
`else
          w_state_next     = ST_IDLE;
`endif
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end

      ST_TURN: begin
        if (w_cnt_zero) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end

      default: begin
        w_state_next      = ST_CHIPRST;
        w_cnt_next        = L_RST_LD;
        w_cs_n_next       = 1'b1;
        w_rd_n_next       = 1'b1;
        w_wr_n_next       = 1'b1;
        w_data_oe_next    = 1'b0;
        w_chip_rst_n_next = 1'b0;
      end
    endcase
  end

  // State and pin registers; reset forces all controls inactive, chip in reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_CHIPRST;
      r_cnt        <= L_RST_LD;
      r_rst_pend   <= 1'b0;
      r_write      <= 1'b0;
      r_cs_n       <= 1'b1;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_chip_rst_n <= 1'b0;
      r_addr       <= '0;
      r_dout       <= '0;
      r_data_oe    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_rst_pend   <= w_rst_pend_next;
      r_write      <= w_write_next;
      r_cs_n       <= w_cs_n_next;
      r_rd_n       <= w_rd_n_next;
      r_wr_n       <= w_wr_n_next;
      r_chip_rst_n <= w_chip_rst_n_next;
      r_addr       <= w_addr_next;
      r_dout       <= w_dout_next;
      r_data_oe    <= w_data_oe_next;
      r_rsp_valid  <= w_rsp_valid_next;
      r_rsp_rdata  <= w_rsp_rdata_next;
    end
  end

  assign io_bus_data   = r_data_oe ? r_dout : {DATA_W{1'bz}};

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.bus_addr  = r_addr;
  assign bus.bus_rd_n  = r_rd_n;
  assign bus.bus_wr_n  = r_wr_n;
  assign bus.bus_cs_n  = r_cs_n;
  assign bus.bus_rst_n = r_chip_rst_n;

endmodule

// File: tb/tb_hpi_bus_master.sv
// tb_hpi_bus_master: directed stimulus with scoreboard queues. The stimulus
// pushes expected responses and expected CS_N windows; two monitor processes
// pop and compare when the DUT presents rsp_valid or closes a CS_N window.
module tb_hpi_bus_master;
  localparam int DW = 16;
  localparam int AW = 2;
`ifdef HPI_TURNAROUND_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hpi_bus_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  wire  [DW-1:0] bus_data;
  logic [DW-1:0] tb_rd_val = '0;

  // Peripheral model: drives read data while RD_N is low.
  assign bus_data = (bus.bus_rd_n == 1'b0) ? tb_rd_val : {DW{1'bz}};

  hpi_bus_master #(
    .DATA_W(DW), .ADDR_W(AW), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1), .RST_CYC(8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .io_bus_data (bus_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] last_rd = '0;

  typedef struct { bit write; logic [DW-1:0] rdata; int due; } rsp_t;
  typedef struct { bit write; logic [AW-1:0] addr; logic [DW-1:0] wdata; int gap; } win_t;
  rsp_t rq[$];
  win_t wq[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  initial forever begin
    rsp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (bus.rsp_valid) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=rsp_valid required=none (cycle %0d)", cyc);
        end else begin
          e = rq.pop_front();
          chk("rsp_latency_cycle", cyc, e.due);
          chk(e.write ? "rsp_rdata_after_write" : "rsp_rdata_read", bus.rsp_rdata, e.rdata);
          $display("rsp %s rdata=%h at cycle %0d", e.write ? "WR" : "RD", bus.rsp_rdata, cyc);
        end
      end else if (rq.size() > 0 && cyc > rq[0].due) begin
        checks++;
        errors++;
        $display("FAIL rsp_timeout actual=no_rsp required=rsp_at_%0d", rq[0].due);
        void'(rq.pop_front());
      end
    end
  end

  // CS_N window monitor
  bit            in_win = 0;
  int            win_len, str_first, rd_low, wr_low, oe_cnt, hi_cnt, stray, gap_start;
  bit            addr_chg, data_chg;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  initial forever begin
    win_t w;
    @(negedge clk);
    if (!rst_n) begin
      in_win = 0;
      hi_cnt = 0;
      stray  = 0;
    end else if (bus.bus_cs_n == 1'b0) begin
      if (!in_win) begin
        in_win = 1; win_len = 0; str_first = 0; rd_low = 0; wr_low = 0; oe_cnt = 0;
        addr_chg = 0; data_chg = 0; win_addr = bus.bus_addr; win_data = bus_data;
        gap_start = hi_cnt;
      end
      win_len++;
      if (!bus.bus_rd_n) rd_low++;
      if (!bus.bus_wr_n) wr_low++;
      if ((!bus.bus_rd_n || !bus.bus_wr_n) && str_first == 0) str_first = win_len;
      if (dut.r_data_oe) oe_cnt++;
      if (bus.bus_addr != win_addr) addr_chg = 1;
      if (bus_data != win_data && dut.r_data_oe) data_chg = 1;
    end else begin
      if (in_win) begin
        in_win = 0;
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cs_window_unexpected actual=window required=none (cycle %0d)", cyc);
        end else begin
          w = wq.pop_front();
          chk("cs_low_len", win_len, 4);
          chk("strobe_first_cycle", str_first, 2);
          chk("rd_low_cycles", rd_low, w.write ? 0 : 2);
          chk("wr_low_cycles", wr_low, w.write ? 2 : 0);
          chk("bus_addr", win_addr, w.addr);
          chk("addr_stable", addr_chg, 0);
          chk("data_oe_cycles", oe_cnt, w.write ? 4 : 0);
          if (w.write) begin
            chk("bus_wdata", win_data, w.wdata);
            chk("wdata_stable", data_chg, 0);
          end
          if (w.gap >= 0) chk("cs_high_gap", gap_start, w.gap);
          chk("idle_pins_inactive", stray, 0);
          $display("win %s addr=%0d len=%0d gap=%0d", w.write ? "WR" : "RD", win_addr, win_len, gap_start);
        end
        hi_cnt = 0;
        stray  = 0;
      end
      hi_cnt++;
      if (!bus.bus_rd_n || !bus.bus_wr_n || dut.r_data_oe) stray++;
    end
  end

  // Issue one request; entered and left just after a negedge.
  task automatic issue(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, bit hold, bit track, int gap);
    bit   ok = 0;
    rsp_t r;
    win_t w;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    if (!wr) tb_rd_val = d;
    for (int n = 0; n < 40; n++) begin
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_ready required=ready (cycle %0d)", cyc);
      bus.req_valid = 1'b0;
      return;
    end
    if (track) begin
      r.write = wr; r.rdata = wr ? last_rd : d; r.due = cyc + 5;
      rq.push_back(r);
      w.write = wr; w.addr = a; w.wdata = d; w.gap = gap;
      wq.push_back(w);
      if (!wr) last_rd = d;
    end
    $display("req %s addr=%0d data=%h accepted at cycle %0d", wr ? "WR" : "RD", a, d, cyc + 1);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  // Measure a BUS_RST_N low pulse (counting from the current sample) and
  // confirm the block is ready right after it.
  task automatic check_chiprst(string name);
    int n = 0;
    int len = 0;
    while (bus.bus_rst_n && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (!bus.bus_rst_n && len < 300) begin
      len++;
      @(negedge clk);
    end
    chk({name, "_rst_len"}, len, 8);
    chk({name, "_ready_after"}, bus.req_ready, 1);
    $display("chiprst %s low=%0d cycles", name, len);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.chip_rst_req = 1'b0;
    rst_n            = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bus_rst_n", bus.bus_rst_n, 0);
    chk("rst_cs_n", bus.bus_cs_n, 1);
    chk("rst_rd_n", bus.bus_rd_n, 1);
    chk("rst_wr_n", bus.bus_wr_n, 1);
    chk("rst_addr", bus.bus_addr, 0);
    chk("rst_data_oe", dut.r_data_oe, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_busy", bus.busy, 1);

    // Power-on chip reset
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_chiprst("power_on");

    // Single write, single read
    issue(1'b1, 2'd2, 16'hA5C3, 1'b0, 1'b1, -1);
    repeat (6) @(negedge clk);
    issue(1'b0, 2'd1, 16'h1234, 1'b0, 1'b1, -1);
    repeat (6) @(negedge clk);

    // Back-to-back write then read with req_valid held
    issue(1'b1, 2'd3, 16'hBEEF, 1'b1, 1'b1, -1);
    issue(1'b0, 2'd0, 16'h5A5A, 1'b0, 1'b1, GAP);
    repeat (8) @(negedge clk);

    // chip_rst_req pulsed during STROBE of a read
    issue(1'b0, 2'd2, 16'hC0DE, 1'b0, 1'b1, -1);
    @(negedge clk);
    bus.chip_rst_req = 1'b1;
    @(negedge clk);
    bus.chip_rst_req = 1'b0;
    check_chiprst("pending");

    // chip_rst_req together with req_valid in IDLE: reset wins
    bus.chip_rst_req = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_addr     = 2'd3;
    #1 chk("rst_wins_req_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.chip_rst_req = 1'b0;
    bus.req_valid    = 1'b0;
    chk("rst_wins_busy", bus.busy, 1);
    check_chiprst("idle_req");

    // Reset_N asserted mid-write
    issue(1'b1, 2'd1, 16'h7777, 1'b0, 1'b0, -1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cs_n", bus.bus_cs_n, 1);
    chk("async_wr_n", bus.bus_wr_n, 1);
    chk("async_rd_n", bus.bus_rd_n, 1);
    chk("async_data_oe", dut.r_data_oe, 0);
    chk("async_bus_rst_n", bus.bus_rst_n, 0);
    chk("async_addr", bus.bus_addr, 0);
    chk("async_busy", bus.busy, 1);
    last_rd = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_chiprst("after_reset");

    // Normal operation again
    issue(1'b1, 2'd0, 16'h1111, 1'b0, 1'b1, -1);
    repeat (6) @(negedge clk);
    issue(1'b0, 2'd3, 16'h0F0F, 1'b0, 1'b1, -1);

    for (int n = 0; n < 60 && (rq.size() > 0 || wq.size() > 0); n++) @(negedge clk);
    if (rq.size() > 0 || wq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d_pending required=0", rq.size() + wq.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
